branch_pc_unit: RTL and testbench
=================================

// Module: branch_pc_unit
// PURPOSE
//   Sits directly downstream of the ALU in the datapath. Latches the ALU's
//   Z/N/V outputs into a status register and evaluates the branch condition.
//   Holds the program counter and computes its next value for increment,
//   PC-relative conditional branch and register-indirect jump. Captures a
//   link address for branch-and-link. Drives pc_out to the instruction
//   memory address mux.
// PARAMETERS
//   PC_W      9    width of the PC, link register and register-target field
//   RESET_PC  0    PC value loaded on reset (PC_W bits)
// PORTS
//   clk         in   1     rising-edge clock
//   reset_n     in   1     asynchronous, active-low reset
//   load_s      in   1     capture Z_in/N_in/V_in into the status register
//   Z_in        in   1     ALU zero flag
//   N_in        in   1     ALU negative flag
//   V_in        in   1     ALU overflow flag
//   pc_op       in   2     00 hold, 01 increment, 10 cond branch, 11 reg jump
//   cond        in   3     branch condition (instruction bits 10:8)
//   imm8        in   8     signed branch offset (two's complement)
//   reg_target  in   PC_W  jump address from a register (BX/BLX)
//   link        in   1     capture pc_out into link_out on this PC update
//   pc_out      out  PC_W  current PC (registered)
//   link_out    out  PC_W  link register (registered)
//   Z, N, V     out  1     status register (registered)
//   taken       out  1     1-cycle pulse: the last pc_op=10 branch was taken
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous): pc_out=RESET_PC, link_out=0, Z=N=V=0,
//     taken=0. All state is held while reset_n is low. Normal operation
//     resumes on the first rising edge after reset is released.
//   All state updates occur on the rising edge of clk. Outputs are registered;
//     no combinational path runs from inputs to outputs.
//   Status register: when load_s=1, {Z,N,V} <= {Z_in,N_in,V_in}. Otherwise the
//     flags hold.
//   Condition evaluation always uses the registered flags. If load_s and
//     pc_op=10 occur in the same cycle, the branch sees the OLD flags.
//   cond encoding (c = condition true):
//     000 always; 001 Z; 010 !Z; 011 N!=V; 100 (N!=V)|Z;
//     101..111 never taken.
//   pc_op=00: pc holds.
//   pc_op=01: pc <= pc_out+1 modulo 2^PC_W (all-ones wraps to 0).
//   pc_op=10: pc_out is already the address of the next instruction.
//     If c: pc <= pc_out + sext(imm8) modulo 2^PC_W.
//     If not c: pc holds.
//     sext sign-extends imm8 to PC_W bits, so the offset spans -128..+127.
//   pc_op=11: pc <= reg_target, unconditionally.
//   link=1 with pc_op!=00: link_out <= pc_out as sampled BEFORE the update,
//     regardless of whether the branch is taken. link is ignored when pc_op=00.
//   taken <= (pc_op==10) & c. It is 0 in every other cycle, giving a
//     one-cycle pulse.
// TESTING
//   Reset mid-run:
//     pc=0x05A, flags 111, reset_n low asynchronously
//     -> pc=0 and flags=000 immediately, before any clock edge.
//   Increment wrap (PC_W=9):
//     pc=0x1FF, pc_op=01 -> pc=0x000.
//   BEQ both ways:
//     load_s with Z_in=1, then pc=0x010, pc_op=10, cond=001, imm8=0xFE
//       -> pc=0x00E, taken=1.
//     Repeat with Z=0 -> pc stays 0x010, taken=0.
//   BLT/BLE:
//     flags N=1,V=0,Z=0, cond=011, imm8=0x05, pc=0x020 -> pc=0x025.
//     N=1,V=1,Z=0, cond=100 -> not taken.
//     N=1,V=1,Z=1, cond=100 -> taken.
//   Same-cycle hazard:
//     registered Z=0; load_s=1 with Z_in=1, pc_op=10, cond=001 together
//     -> not taken, and Z=1 afterwards.
//   BLX:
//     pc=0x030, pc_op=11, link=1, reg_target=0x1A0
//       -> pc=0x1A0, link_out=0x030.
//     Negative-offset wrap: pc=0x002, imm8=0x80, cond=000 -> pc=0x182.

Source files
------------

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: status flags, branch condition evaluation and program counter.
//   clk, reset_n             clock and asynchronous active-low reset
//   load_s, Z_in/N_in/V_in   capture ALU flags into the status register
//   pc_op                    00 hold, 01 increment, 10 cond branch, 11 reg jump
//   cond, imm8               branch condition code and signed offset
//   reg_target               register-indirect jump address
//   link                     capture the pre-update PC into link_out
//   pc_out, link_out         registered PC and link register
//   Z, N, V                  registered status flags
//   taken                    one-cycle pulse for a taken conditional branch
module branch_pc_unit #(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_s,
  input  logic            Z_in,
  input  logic            N_in,
  input  logic            V_in,
  input  logic [1:0]      pc_op,
  input  logic [2:0]      cond,
  input  logic [7:0]      imm8,
  input  logic [PC_W-1:0] reg_target,
  input  logic            link,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] link_out,
  output logic            Z,
  output logic            N,
  output logic            V,
  output logic            taken
);

  localparam int unsigned IMM_W = 8;
  localparam int unsigned EXT_W = PC_W - IMM_W;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] link_q, link_d;
  logic            z_q, z_d;
  logic            n_q, n_d;
  logic            v_q, v_d;
  logic            taken_q, taken_d;
  logic            cond_c;
  logic [PC_W-1:0] offset_c;

  // Branch condition from the registered flags only, so a same-cycle flag load
  // never influences the branch it accompanies.
  always_comb begin
    cond_c = 1'b0;
    case (cond)
      3'b000:  cond_c = 1'b1;
      3'b001:  cond_c = z_q;
      3'b010:  cond_c = ~z_q;
      3'b011:  cond_c = n_q ^ v_q;
      3'b100:  cond_c = (n_q ^ v_q) | z_q;
      default: cond_c = 1'b0;
    endcase
  end

  // Sign-extended branch offset.
  always_comb begin
    offset_c = {{EXT_W{imm8[IMM_W-1]}}, imm8};
  end

  // Next-state computation for PC, link, flags and the taken pulse.
  always_comb begin
    pc_d    = pc_q;
    link_d  = link_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    taken_d = 1'b0;

    if (load_s) begin
      z_d = Z_in;
      n_d = N_in;
      v_d = V_in;
    end

    case (pc_op)
      OP_INC:  pc_d = pc_q + PC_W'(1);
      OP_BR: begin
        taken_d = cond_c;
        if (cond_c) begin
          pc_d = pc_q + offset_c;
        end
      end
      OP_JMP:  pc_d = reg_target;
      default: pc_d = pc_q;
    endcase

    // Link captures the PC as it was before this update, taken or not.
    if (link && (pc_op != OP_HOLD)) begin
      link_d = pc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      link_q  <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      link_q  <= link_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      taken_q <= taken_d;
    end
  end

  assign pc_out   = pc_q;
  assign link_out = link_q;
  assign Z        = z_q;
  assign N        = n_q;
  assign V        = v_q;
  assign taken    = taken_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: a driver applies directed and random
// operations and queues the expected post-edge state from an arithmetic
// reference model; a monitor pops and compares after each rising edge.
module tb_branch_pc_unit;

  localparam int PC_W = 9;
  localparam int PC_MOD = 512;

  logic            clk;
  logic            reset_n;
  logic            load_s;
  logic            Z_in, N_in, V_in;
  logic [1:0]      pc_op;
  logic [2:0]      cond;
  logic [7:0]      imm8;
  logic [PC_W-1:0] reg_target;
  logic            link;
  logic [PC_W-1:0] pc_out;
  logic [PC_W-1:0] link_out;
  logic            Z, N, V;
  logic            taken;

  branch_pc_unit #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
    .clk(clk), .reset_n(reset_n), .load_s(load_s),
    .Z_in(Z_in), .N_in(N_in), .V_in(V_in),
    .pc_op(pc_op), .cond(cond), .imm8(imm8), .reg_target(reg_target),
    .link(link), .pc_out(pc_out), .link_out(link_out),
    .Z(Z), .N(N), .V(V), .taken(taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int lnk;
    int flags;
    int tk;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference state.
  int m_pc, m_link;
  bit m_z, m_n, m_v;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_link = 0; m_z = 0; m_n = 0; m_v = 0;
  endtask

  // Drive one operation for the next rising edge and queue its expected result.
  task automatic step(input bit ls, input bit zi, input bit ni, input bit vi,
                      input int op, input int c, input int im, input int rt,
                      input bit lk);
    bit   ct;
    bit   tk;
    int   off;
    exp_t e;
    @(negedge clk);
    load_s = ls; Z_in = zi; N_in = ni; V_in = vi;
    pc_op = 2'(op); cond = 3'(c); imm8 = 8'(im); reg_target = 9'(rt); link = lk;

    case (c)
      0:       ct = 1;
      1:       ct = m_z;
      2:       ct = !m_z;
      3:       ct = (m_n != m_v);
      4:       ct = (m_n != m_v) || m_z;
      default: ct = 0;
    endcase
    off = (im >= 128) ? im - 256 : im;
    tk  = (op == 2) && ct;
    if (lk && op != 0) m_link = m_pc;
    case (op)
      1: m_pc = (m_pc + 1) % PC_MOD;
      2: if (ct) m_pc = (m_pc + off + PC_MOD) % PC_MOD;
      3: m_pc = rt % PC_MOD;
      default: ;
    endcase
    if (ls) begin m_z = zi; m_n = ni; m_v = vi; end

    e.pc = m_pc; e.lnk = m_link; e.flags = {29'd0, m_z, m_n, m_v}; e.tk = int'(tk);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    load_s = 0; Z_in = 0; N_in = 0; V_in = 0; pc_op = 2'b00; cond = 3'b000;
    imm8 = 8'h00; reg_target = '0; link = 0;
  endtask

  // Look at the DUT right after the edge that consumed the last step.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered update against the queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (reset_n && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_pc",    int'(pc_out),   e.pc);
      chk("sb_link",  int'(link_out), e.lnk);
      chk("sb_flags", int'({Z, N, V}), e.flags);
      chk("sb_taken", int'(taken),    e.tk);
    end
  end

  initial begin
    idle();
    model_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc",    int'(pc_out),    0);
    chk("rst_link",  int'(link_out),  0);
    chk("rst_flags", int'({Z, N, V}), 0);
    chk("rst_taken", int'(taken),     0);
    @(negedge clk);
    reset_n = 1;

    // Increment wrap.
    step(0, 0, 0, 0, 3, 0, 0, 'h1FF, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    after_edge();
    chk("inc_wrap", int'(pc_out), 'h000);

    // BEQ taken with Z=1, offset -2.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3, 0, 0, 'h010, 0);
    step(0, 0, 0, 0, 2, 1, 'hFE, 0, 0);
    after_edge();
    chk("beq_pc", int'(pc_out), 'h00E);
    chk("beq_taken", int'(taken), 1);

    // BEQ not taken with Z=0.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3, 0, 0, 'h010, 0);
    step(0, 0, 0, 0, 2, 1, 'hFE, 0, 0);
    after_edge();
    chk("bne_pc", int'(pc_out), 'h010);
    chk("bne_taken", int'(taken), 0);

    // BLT taken, BLE not taken, BLE taken.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3, 0, 0, 'h020, 0);
    step(0, 0, 0, 0, 2, 3, 'h05, 0, 0);
    after_edge();
    chk("blt_pc", int'(pc_out), 'h025);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2, 4, 'h05, 0, 0);
    after_edge();
    chk("ble_nt_pc", int'(pc_out), 'h025);
    chk("ble_nt_taken", int'(taken), 0);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2, 4, 'h05, 0, 0);
    after_edge();
    chk("ble_t_pc", int'(pc_out), 'h02A);

    // Same-cycle flag load and branch: branch sees old Z=0.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 2, 1, 'h10, 0, 0);
    after_edge();
    chk("hazard_taken", int'(taken), 0);
    chk("hazard_z", int'(Z), 1);

    // BLX.
    step(0, 0, 0, 0, 3, 0, 0, 'h030, 0);
    step(0, 0, 0, 0, 3, 0, 0, 'h1A0, 1);
    after_edge();
    chk("blx_pc", int'(pc_out), 'h1A0);
    chk("blx_link", int'(link_out), 'h030);

    // Negative offset wrap.
    step(0, 0, 0, 0, 3, 0, 0, 'h002, 0);
    step(0, 0, 0, 0, 2, 0, 'h80, 0, 0);
    after_edge();
    chk("neg_wrap", int'(pc_out), 'h182);

    // Asynchronous reset mid-run.
    step(0, 0, 0, 0, 3, 0, 0, 'h05A, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    after_edge();
    idle();
    #1;
    reset_n = 0;
    #1;
    chk("async_rst_pc", int'(pc_out), 0);
    chk("async_rst_flags", int'({Z, N, V}), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;

    // Randomized operations.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255),
           $urandom_range(0, PC_MOD - 1), 1'($urandom_range(0, 1)));
    end
    after_edge();
    idle();
    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
